// File: rtl/sgpr_file_v2_if.sv
// rtl/sgpr_file_v2_if.sv - operand-fetch / writeback bundle for the scalar register file
interface sgpr_file_v2_if #(
  parameter int ADDR_W = 8
);
  logic              rd0_en;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_wide;
  logic [63:0]       rd0_data;
  logic              rd0_valid;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_wide;
  logic [63:0]       rd1_data;
  logic              rd1_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_wide;
  logic [63:0]       wr_data;
  logic              exec_we;
  logic [63:0]       exec_in;
  logic              scc_we;
  logic              scc_in;
  logic [63:0]       exec_out;
  logic              scc_out;
  logic              vccz_out;
  logic              execz_out;
  logic              err;

  modport master (
    output rd0_en, rd0_addr, rd0_wide, rd1_en, rd1_addr, rd1_wide,
    output wr_en, wr_addr, wr_wide, wr_data, exec_we, exec_in, scc_we, scc_in,
    input  rd0_data, rd0_valid, rd1_data, rd1_valid,
    input  exec_out, scc_out, vccz_out, execz_out, err
  );

  modport slave (
    input  rd0_en, rd0_addr, rd0_wide, rd1_en, rd1_addr, rd1_wide,
    input  wr_en, wr_addr, wr_wide, wr_data, exec_we, exec_in, scc_we, scc_in,
    output rd0_data, rd0_valid, rd1_data, rd1_valid,
    output exec_out, scc_out, vccz_out, execz_out, err
  );
endinterface

// File: rtl/sgpr_file_v2.sv
// rtl/sgpr_file_v2.sv - scalar register file: 2 registered read ports, 1 write port, VCC/EXEC/SCC
module sgpr_file_v2 #(
  parameter int ADDR_W   = 8,
  parameter int NUM_SGPR = 106,
  parameter int VCC_LO   = 106,
  parameter int EXEC_LO  = 126,
  parameter int RO_BASE  = 128
) (
  input logic           clock,
  input logic           reset,
  sgpr_file_v2_if.slave bus
);

  localparam logic [ADDR_W-1:0] VCC_LO_A  = ADDR_W'(VCC_LO);
  localparam logic [ADDR_W-1:0] VCC_HI_A  = ADDR_W'(VCC_LO + 1);
  localparam logic [ADDR_W-1:0] EXEC_LO_A = ADDR_W'(EXEC_LO);
  localparam logic [ADDR_W-1:0] EXEC_HI_A = ADDR_W'(EXEC_LO + 1);
  localparam logic [ADDR_W:0]   RO_A      = (ADDR_W + 1)'(RO_BASE);

  logic [31:0] sgpr      [NUM_SGPR];
  logic [31:0] next_sgpr [NUM_SGPR];
  logic [63:0] vcc, next_vcc;
  logic [63:0] exec_q, next_exec;
  logic        scc;

  logic [63:0] rd0_q, rd1_q, rd0_next, rd1_next;
  logic        rd0_valid_q, rd1_valid_q, err_q, err_next;

  logic              wr_ro, wr_odd, wr_ok;
  logic [ADDR_W-1:0] wr_hi_addr;
  logic              rd0_odd, rd1_odd;

  assign wr_ro      = ({1'b0, bus.wr_addr} >= RO_A);
  assign wr_odd     = bus.wr_wide & bus.wr_addr[0];
  assign wr_ok      = bus.wr_en & ~wr_ro & ~wr_odd;
  assign wr_hi_addr = {bus.wr_addr[ADDR_W-1:1], 1'b1};
  assign rd0_odd    = bus.rd0_wide & bus.rd0_addr[0];
  assign rd1_odd    = bus.rd1_wide & bus.rd1_addr[0];

  // Next-state of every word; reads sample this, which gives write-first forwarding per word.
  always_comb begin
    next_sgpr = sgpr;
    next_vcc  = vcc;
    next_exec = exec_q;
    if (wr_ok) begin
      for (int i = 0; i < NUM_SGPR; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) next_sgpr[i] = bus.wr_data[31:0];
        if (bus.wr_wide && wr_hi_addr == ADDR_W'(i)) next_sgpr[i] = bus.wr_data[63:32];
      end
      if (bus.wr_addr == VCC_LO_A) next_vcc[31:0] = bus.wr_data[31:0];
      if (bus.wr_addr == VCC_HI_A) next_vcc[63:32] = bus.wr_data[31:0];
      if (bus.wr_wide && wr_hi_addr == VCC_HI_A) next_vcc[63:32] = bus.wr_data[63:32];
      if (bus.wr_addr == EXEC_LO_A) next_exec[31:0] = bus.wr_data[31:0];
      if (bus.wr_addr == EXEC_HI_A) next_exec[63:32] = bus.wr_data[31:0];
      if (bus.wr_wide && wr_hi_addr == EXEC_HI_A) next_exec[63:32] = bus.wr_data[63:32];
    end
    if (bus.exec_we) next_exec = bus.exec_in;
  end

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    word_at = '0;
    for (int i = 0; i < NUM_SGPR; i++)
      if (a == ADDR_W'(i)) word_at = next_sgpr[i];
    if (a == VCC_LO_A)  word_at = next_vcc[31:0];
    if (a == VCC_HI_A)  word_at = next_vcc[63:32];
    if (a == EXEC_LO_A) word_at = next_exec[31:0];
    if (a == EXEC_HI_A) word_at = next_exec[63:32];
  endfunction

  always_comb begin
    rd0_next = '0;
    rd1_next = '0;
    if (!rd0_odd)
      rd0_next = bus.rd0_wide ? {word_at({bus.rd0_addr[ADDR_W-1:1], 1'b1}), word_at(bus.rd0_addr)}
                              : {32'b0, word_at(bus.rd0_addr)};
    if (!rd1_odd)
      rd1_next = bus.rd1_wide ? {word_at({bus.rd1_addr[ADDR_W-1:1], 1'b1}), word_at(bus.rd1_addr)}
                              : {32'b0, word_at(bus.rd1_addr)};
    err_next = (bus.wr_en & (wr_ro | wr_odd)) | (bus.rd0_en & rd0_odd) | (bus.rd1_en & rd1_odd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SGPR; i++) sgpr[i] <= '0;
      vcc         <= '0;
      exec_q      <= '0;
      scc         <= 1'b0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sgpr        <= next_sgpr;
      vcc         <= next_vcc;
      exec_q      <= next_exec;
      if (bus.scc_we) scc <= bus.scc_in;
      if (bus.rd0_en) rd0_q <= rd0_next;
      if (bus.rd1_en) rd1_q <= rd1_next;
      rd0_valid_q <= bus.rd0_en;
      rd1_valid_q <= bus.rd1_en;
      err_q       <= err_next;
    end
  end

  assign bus.rd0_data  = rd0_q;
  assign bus.rd0_valid = rd0_valid_q;
  assign bus.rd1_data  = rd1_q;
  assign bus.rd1_valid = rd1_valid_q;
  assign bus.exec_out  = exec_q;
  assign bus.scc_out   = scc;
  assign bus.vccz_out  = ~|vcc;
  assign bus.execz_out = ~|exec_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sgpr_file_v2.sv
// tb/tb_sgpr_file_v2.sv - directed bench for sgpr_file_v2
module tb_sgpr_file_v2;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  sgpr_file_v2_if #(.ADDR_W(8)) bus ();

  sgpr_file_v2 #(
    .ADDR_W(8), .NUM_SGPR(106), .VCC_LO(106), .EXEC_LO(126), .RO_BASE(128)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd0_en = 0; bus.rd0_addr = '0; bus.rd0_wide = 0;
    bus.rd1_en = 0; bus.rd1_addr = '0; bus.rd1_wide = 0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_wide = 0; bus.wr_data = '0;
    bus.exec_we = 0; bus.exec_in = '0; bus.scc_we = 0; bus.scc_in = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd0(input logic [7:0] a, input logic w);
    bus.rd0_en = 1; bus.rd0_addr = a; bus.rd0_wide = w;
  endtask

  task automatic rd1(input logic [7:0] a, input logic w);
    bus.rd1_en = 1; bus.rd1_addr = a; bus.rd1_wide = w;
  endtask

  task automatic wr(input logic [7:0] a, input logic w, input logic [63:0] d);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_wide = w; bus.wr_data = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;

    check("rst_rd0_valid", 64'(bus.rd0_valid), 64'd0);
    check("rst_rd0_data", bus.rd0_data, 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_vccz", 64'(bus.vccz_out), 64'd1);
    check("rst_execz", 64'(bus.execz_out), 64'd1);
    check("rst_scc", 64'(bus.scc_out), 64'd0);
    check("rst_exec", bus.exec_out, 64'd0);

    rd0(8'd0, 0); rd1(8'd126, 1);
    tick();
    check("s0_read", bus.rd0_data, 64'd0);
    check("exec_pair_read", bus.rd1_data, 64'd0);
    check("rd0_valid", 64'(bus.rd0_valid), 64'd1);
    check("rd1_valid", 64'(bus.rd1_valid), 64'd1);
    tick();
    check("rd0_valid_drop", 64'(bus.rd0_valid), 64'd0);
    check("rd0_data_hold", bus.rd0_data, 64'd0);

    wr(8'd4, 1, 64'hDEADBEEF_12345678);
    tick();
    rd0(8'd4, 1); rd1(8'd5, 0);
    tick();
    check("wide_rd4", bus.rd0_data, 64'hDEADBEEF_12345678);
    check("narrow_rd5", bus.rd1_data, 64'h00000000_DEADBEEF);
    check("no_err_legal", 64'(bus.err), 64'd0);

    wr(8'd11, 0, 64'h1);
    tick();
    wr(8'd10, 0, 64'hFFFF_FFFF_AAAA5555); rd0(8'd10, 1); rd1(8'd11, 0);
    tick();
    check("fwd_low_half", bus.rd0_data, 64'h00000001_AAAA5555);
    check("narrow_no_upper_write", bus.rd1_data, 64'h1);

    wr(8'h90, 0, 64'h1234); rd0(8'd7, 1); rd1(8'h90, 0);
    tick();
    check("err_pulse", 64'(bus.err), 64'd1);
    check("odd_wide_rd_zero", bus.rd0_data, 64'd0);
    check("odd_wide_rd_valid", 64'(bus.rd0_valid), 64'd1);
    check("ro_read_zero", bus.rd1_data, 64'd0);
    rd0(8'd6, 1);
    tick();
    check("err_one_cycle", 64'(bus.err), 64'd0);
    check("s6_s7_untouched", bus.rd0_data, 64'd0);

    wr(8'd5, 1, 64'h5555_5555_6666_6666); rd0(8'd4, 1);
    tick();
    check("odd_wide_wr_err", 64'(bus.err), 64'd1);
    check("odd_wide_wr_dropped", bus.rd0_data, 64'hDEADBEEF_12345678);

    wr(8'd110, 0, 64'h77); rd0(8'd110, 0);
    tick();
    check("unmapped_no_err", 64'(bus.err), 64'd0);
    check("unmapped_read_zero", bus.rd0_data, 64'd0);

    wr(8'd126, 1, 64'h1); bus.exec_we = 1; bus.exec_in = 64'hF0;
    tick();
    check("exec_we_wins", bus.exec_out, 64'hF0);
    check("execz_clear", 64'(bus.execz_out), 64'd0);
    rd0(8'd126, 1);
    tick();
    check("exec_read", bus.rd0_data, 64'hF0);
    bus.exec_we = 1; bus.exec_in = 64'h0;
    tick();
    check("execz_set", 64'(bus.execz_out), 64'd1);

    bus.scc_we = 1; bus.scc_in = 1;
    tick();
    check("scc_set", 64'(bus.scc_out), 64'd1);

    wr(8'd106, 1, 64'h00000001_00000000);
    tick();
    check("vccz_clear", 64'(bus.vccz_out), 64'd0);
    rd0(8'd107, 0);
    tick();
    check("vcc_hi_read", bus.rd0_data, 64'h1);

    reset = 1; rd0(8'd4, 1);
    tick();
    reset = 0;
    check("mid_rst_valid", 64'(bus.rd0_valid), 64'd0);
    check("mid_rst_data", bus.rd0_data, 64'd0);
    check("mid_rst_vccz", 64'(bus.vccz_out), 64'd1);
    check("mid_rst_scc", 64'(bus.scc_out), 64'd0);
    check("mid_rst_exec", bus.exec_out, 64'd0);
    rd0(8'd4, 1);
    tick();
    check("mid_rst_s4_cleared", bus.rd0_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
